// File: rtl/line_clear_engine_if.sv
// rtl/line_clear_engine_if.sv - board RAM port bundle between the line clear engine and the RAM mux
interface line_clear_engine_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8
);
    logic                     ram_wEn;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]    ram_dataIn;
    logic [DATA_WIDTH-1:0]    ram_dataOut;

    modport master (
        output ram_wEn,
        output ram_addr,
        output ram_dataIn,
        input  ram_dataOut
    );

    modport slave (
        input  ram_wEn,
        input  ram_addr,
        input  ram_dataIn,
        output ram_dataOut
    );
endinterface

// File: rtl/line_clear_engine.sv
// rtl/line_clear_engine.sv - bottom-up full-row removal pass over the Tetris board RAM
module line_clear_engine #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int COLS          = 10,
    parameter int ROWS          = 20,
    parameter int EMPTY         = 0,
    parameter int CNT_WIDTH     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] lines_cleared,
    line_clear_engine_if.master  ram
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    typedef enum logic [2:0] {
        IDLE, SCAN_RD, SCAN_CHK, SHIFT_RD, SHIFT_WR, CLEAR, DONE
    } state_t;

    state_t               state, state_n;
    logic [ROW_W-1:0]     row, row_n;
    logic [ROW_W-1:0]     dst, dst_n;
    logic [COL_W-1:0]     col, col_n;
    logic [CNT_WIDTH-1:0] lc_n;

    function automatic logic [ADDRESS_WIDTH-1:0] addr_of(input logic [ROW_W-1:0] r,
                                                         input logic [COL_W-1:0] c);
        return ADDRESS_WIDTH'(r) * ADDRESS_WIDTH'(COLS) + ADDRESS_WIDTH'(c);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            row           <= '0;
            dst           <= '0;
            col           <= '0;
            lines_cleared <= '0;
        end else begin
            state         <= state_n;
            row           <= row_n;
            dst           <= dst_n;
            col           <= col_n;
            lines_cleared <= lc_n;
        end
    end

    always_comb begin
        state_n = state;
        row_n   = row;
        dst_n   = dst;
        col_n   = col;
        lc_n    = lines_cleared;
        case (state)
            IDLE: if (start) begin
                row_n   = ROW_W'(ROWS - 1);
                col_n   = '0;
                lc_n    = '0;
                state_n = SCAN_RD;
            end
            SCAN_RD: state_n = SCAN_CHK;
            SCAN_CHK: begin
                if (ram.ram_dataOut == DATA_WIDTH'(EMPTY)) begin
                    if (row == '0) begin
                        state_n = DONE;
                    end else begin
                        row_n   = row - ROW_W'(1);
                        col_n   = '0;
                        state_n = SCAN_RD;
                    end
                end else if (col != LAST_COL) begin
                    col_n   = col + COL_W'(1);
                    state_n = SCAN_RD;
                end else begin
                    lc_n    = lines_cleared + CNT_WIDTH'(1);
                    dst_n   = row;
                    col_n   = '0;
                    state_n = (row == '0) ? CLEAR : SHIFT_RD;
                end
            end
            SHIFT_RD: state_n = SHIFT_WR;
            SHIFT_WR: begin
                if (col != LAST_COL) begin
                    col_n   = col + COL_W'(1);
                    state_n = SHIFT_RD;
                end else begin
                    col_n   = '0;
                    dst_n   = dst - ROW_W'(1);
                    state_n = (dst == ROW_W'(1)) ? CLEAR : SHIFT_RD;
                end
            end
            CLEAR: begin
                if (col != LAST_COL) begin
                    col_n = col + COL_W'(1);
                end else begin
                    // row keeps its value: the cleared row now holds what was above it
                    col_n   = '0;
                    state_n = SCAN_RD;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ram.ram_wEn    = 1'b0;
        ram.ram_addr   = '0;
        ram.ram_dataIn = '0;
        case (state)
            SCAN_RD, SCAN_CHK: ram.ram_addr = addr_of(row, col);
            SHIFT_RD:          ram.ram_addr = addr_of(dst - ROW_W'(1), col);
            SHIFT_WR: begin
                ram.ram_wEn    = 1'b1;
                ram.ram_addr   = addr_of(dst, col);
                ram.ram_dataIn = ram.ram_dataOut;
            end
            CLEAR: begin
                ram.ram_wEn    = 1'b1;
                ram.ram_addr   = addr_of('0, col);
                ram.ram_dataIn = DATA_WIDTH'(EMPTY);
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule
